// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// mem_loader : streams a program into code memory, pads it with 0x00 and
// clears the data tape. Optional macro BF_FILTER_EN.           Rev 1.0
// ============================================================================
module mem_loader #(
  parameter int CODE_BASE  = 0,
  parameter int CODE_DEPTH = 256,
  parameter int DATA_BASE  = 256,
  parameter int DATA_DEPTH = 256,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [7:0]        writeData,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] code_len,
  output logic              overflow
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0]  C_CODE_END  = IDX_W'(CODE_DEPTH);
  localparam logic [IDX_W-1:0]  C_CODE_LAST = IDX_W'(CODE_DEPTH - 1);
  localparam logic [IDX_W-1:0]  C_DATA_LAST = IDX_W'(DATA_DEPTH - 1);
  localparam logic [ADDR_W-1:0] C_CODE_ADDR = ADDR_W'(CODE_BASE);
  localparam logic [ADDR_W-1:0] C_DATA_ADDR = ADDR_W'(DATA_BASE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_PAD    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] code_len_q, code_len_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              keep;
  logic              room;
  logic [IDX_W-1:0]  idx_after;

  always_comb begin
`ifdef BF_FILTER_EN
    case (in_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: keep = 1'b1;
      default:                                                 keep = 1'b0;
    endcase
`else
    keep = 1'b1;
`endif
  end

  assign room      = (idx_q < C_CODE_END);
  assign idx_after = (keep && room) ? idx_q + 1'b1 : idx_q;
  assign in_ready  = (state_q == S_LOAD);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    code_len_d = code_len_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          idx_d      = '0;
          code_len_d = '0;
          ovf_d      = 1'b0;
        end
      end
      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = C_DATA_ADDR + idx_q[ADDR_W-1:0];
        wdata_d = 8'h00;
        if (idx_q == C_DATA_LAST) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (keep && room) begin
            we_d       = 1'b1;
            waddr_d    = C_CODE_ADDR + idx_q[ADDR_W-1:0];
            wdata_d    = in_data;
            code_len_d = code_len_q + 1'b1;
          end else if (keep) begin
            // Full code region: the rest of the stream is drained unwritten.
            ovf_d = 1'b1;
          end
          idx_d = idx_after;
          if (in_last) begin
            state_d = (idx_after < C_CODE_END) ? S_PAD : S_FINISH;
          end
        end
      end
      S_PAD: begin
        we_d    = 1'b1;
        waddr_d = C_CODE_ADDR + idx_q[ADDR_W-1:0];
        wdata_d = 8'h00;
        idx_d   = idx_q + 1'b1;
        if (idx_q == C_CODE_LAST) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 8'h00;
      code_len_q <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      code_len_q <= code_len_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign writeEnable = we_q;
  assign writeaddr   = waddr_q;
  assign writeData   = wdata_q;
  assign code_len    = code_len_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire
